exposure_timer: RTL

Exposure-time configuration and countdown block for the camera controller. Holds the user-selected exposure time (2–30 ms) and adjusts it from the Exp_increase/Exp_decrease buttons while the camera is idle. On a Start pulse from the exposure-control FSM it times the exposure and returns a one-cycle Ovf5 pulse when the exposure has elapsed. It sits between the button inputs and the exposure-control FSM, and owns the only copy of the exposure setting.

---
 rtl/camera_pkg.sv | 34 +++
 rtl/exp_prescaler.sv | 32 +++
 rtl/exposure_timer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared camera-controller types: exposure FSM states, setting width and limits.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package camera_pkg;

    localparam int EXP_W       = 5;
    localparam int EXP_MIN_DEF = 2;
    localparam int EXP_MAX_DEF = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One saturating step of the exposure setting; opposing edges cancel out.
    function automatic logic [EXP_W-1:0] exp_step(
        input logic [EXP_W-1:0] cur,
        input logic             up,
        input logic             dn,
        input logic [EXP_W-1:0] lo,
        input logic [EXP_W-1:0] hi
    );
        logic [EXP_W-1:0] res;
        res = cur;
        if (up && !dn && (cur < hi)) begin
            res = cur + EXP_W'(1);
        end else if (dn && !up && (cur > lo)) begin
            res = cur - EXP_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/exp_prescaler.sv
// Millisecond tick generator: counts Clk cycles modulo TICK_DIV while enabled.
// Latency: tick is decoded from the count register, high in the last cycle of each ms.
// Backpressure: none; clr overrides en and holds the count at zero.
module exp_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    // Cycle counter that wraps after TICK_DIV cycles.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + PW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/exposure_timer.sv
// Exposure setting register (button adjust while idle) and ms-resolution exposure countdown.
// Latency: Busy from the Start edge; Ovf5 one-cycle pulse Exp_time*TICK_DIV edges after Start.
// Backpressure: none; Start and button edges outside IDLE are dropped, not queued.
module exposure_timer
    import camera_pkg::*;
#(
    parameter int EXP_MIN   = EXP_MIN_DEF,
    parameter int EXP_MAX   = EXP_MAX_DEF,
    parameter int EXP_RESET = 2,
    parameter int TICK_DIV  = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Start,
    input  logic             Abort,
    output logic [EXP_W-1:0] Exp_time,
    output logic             Busy,
    output logic             Ovf5
);

    // Limits are kept in the setting's own 5-bit unsigned domain so every
    // compare below is same-width.
    localparam logic [EXP_W-1:0] EXP_MIN_V   = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] EXP_MAX_V   = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_RESET_V = EXP_W'(EXP_RESET);

    state_t           state;
    state_t           state_nxt;
    logic             inc_prev;
    logic             dec_prev;
    logic             inc_edge;
    logic             dec_edge;
    logic             start_load;
    logic [EXP_W-1:0] remaining;
    logic             pre_clr;
    logic             pre_en;
    logic             tick;
    logic             last_ms;

    assign inc_edge   = Exp_increase && !inc_prev;
    assign dec_edge   = Exp_decrease && !dec_prev;
    assign start_load = (state == IDLE) && Start;
    assign last_ms    = tick && (remaining == EXP_W'(1));

    // The prescaler only runs while counting; an abort clears it on the same edge
    // that returns the FSM to IDLE so a following Start begins from zero.
    assign pre_en  = (state == COUNT);
    assign pre_clr = (state != COUNT) || Abort;

    exp_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    // Button history is sampled in every state so a button held through an
    // exposure cannot produce a late edge once the block is idle again.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inc_prev <= 1'b0;
            dec_prev <= 1'b0;
        end else begin
            inc_prev <= Exp_increase;
            dec_prev <= Exp_decrease;
        end
    end

    // Exposure setting: adjustable only in IDLE, and Start wins over a same-cycle edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Exp_time <= EXP_RESET_V;
        end else if ((state == IDLE) && !Start) begin
            Exp_time <= exp_step(Exp_time, inc_edge, dec_edge, EXP_MIN_V, EXP_MAX_V);
        end
    end

    // Remaining whole milliseconds of the running exposure.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            remaining <= '0;
        end else if (start_load) begin
            remaining <= Exp_time;
        end else if (state == COUNT) begin
            if (Abort) begin
                remaining <= '0;
            end else if (tick && (remaining != '0)) begin
                remaining <= remaining - EXP_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: Abort outranks the terminal tick; DONE lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (last_ms) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally.
    assign Busy = (state != IDLE);
    assign Ovf5 = (state == DONE);

endmodule
